// File: rtl/factorial_decoder.sv
// rtl/factorial_decoder.sv - iterative inverse of the scaled factorial: finds the largest n with (n! << SCALE_SHIFT) <= value
module factorial_decoder #(
  parameter int SCALE_SHIFT = 1,
  parameter int MAX_N       = 12,
  parameter int VAL_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [VAL_W-1:0] value_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       n_out,
  output logic             exact
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] MAX_K = 4'(MAX_N);

  state_t           state;
  logic [VAL_W-1:0] val;
  logic [63:0]      prod;
  logic [3:0]       k;

  logic [63:0] val_ext;
  logic [63:0] prod_scaled;
  logic [63:0] nxt;
  logic [63:0] nxt_scaled;

  // 64-bit working width keeps prod*(k+1) and the shifted compares free of overflow
  always_comb begin
    val_ext     = 64'(val);
    prod_scaled = prod << SCALE_SHIFT;
    nxt         = prod * (64'(k) + 64'd1);
    nxt_scaled  = nxt << SCALE_SHIFT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      val   <= '0;
      prod  <= 64'd1;
      k     <= 4'd1;
      busy  <= 1'b0;
      done  <= 1'b0;
      n_out <= 4'd0;
      exact <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            val   <= value_in;
            prod  <= 64'd1;
            k     <= 4'd1;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (prod_scaled > val_ext) begin
            n_out <= 4'd0;
            exact <= 1'b0;
            state <= DONE;
          end else if (k == MAX_K || nxt_scaled > val_ext) begin
            n_out <= k;
            exact <= (prod_scaled == val_ext);
            state <= DONE;
          end else begin
            prod <= nxt;
            k    <= k + 4'd1;
          end
        end
        DONE: begin
          // completion pulse lands on the cycle after DONE, as busy drops
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_decoder.sv
// tb/tb_factorial_decoder.sv - self-checking bench for factorial_decoder against an arithmetic reference
module tb_factorial_decoder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] value_in;
  logic        busy;
  logic        done;
  logic [3:0]  n_out;
  logic        exact;

  int passed;
  int total;

  factorial_decoder #(.SCALE_SHIFT(1), .MAX_N(12), .VAL_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value_in (value_in),
    .busy     (busy),
    .done     (done),
    .n_out    (n_out),
    .exact    (exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] fact(input int n);
    logic [63:0] f;
    f = 64'd1;
    for (int i = 2; i <= n; i++) f = f * 64'(i);
    return f;
  endfunction

  // Largest n in 0..12 with 2*n! <= v; exact when 2*n! equals v
  task automatic ref_decode(input logic [31:0] v, output int n, output logic ex, output int lat);
    n = 0;
    for (int i = 1; i <= 12; i++)
      if ((fact(i) << 1) <= 64'(v)) n = i;
    ex  = ((fact(n) << 1) == 64'(v));
    lat = ((n < 1) ? 1 : n) + 1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic run_job(input logic [31:0] v, input bit hold, input logic [31:0] v_next);
    int   n_exp, lat_exp, cyc, busy_cnt;
    logic ex_exp;
    ref_decode(v, n_exp, ex_exp, lat_exp);
    @(negedge clk);
    start    = 1'b1;
    value_in = v;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    value_in = hold ? v_next : $urandom;
    busy_cnt = busy ? 1 : 0;
    cyc      = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (busy) busy_cnt++;
    end
    check($sformatf("latency v=%0d", v), 64'(cyc), 64'(lat_exp));
    check($sformatf("n_out v=%0d", v), 64'(n_out), 64'(n_exp));
    check($sformatf("exact v=%0d", v), 64'(exact), 64'(ex_exp));
    check($sformatf("busy cycles v=%0d", v), 64'(busy_cnt), 64'(lat_exp));
    check($sformatf("busy low at done v=%0d", v), 64'(busy), 64'd0);
    if (!hold) begin
      @(posedge clk);
      #1;
      check($sformatf("done one pulse v=%0d", v), 64'(done), 64'd0);
    end
  endtask

  initial begin
    int   cyc, dones;
    logic [31:0] v;
    passed   = 0;
    total    = 0;
    reset    = 1'b0;
    start    = 1'b0;
    value_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset n_out", 64'(n_out), 64'd0);
    check("reset exact", 64'(exact), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_job(32'd240, 0, 0);
    run_job(32'd241, 0, 0);
    run_job(32'd1439, 0, 0);
    run_job(32'd1440, 0, 0);
    run_job(32'd0, 0, 0);
    run_job(32'd1, 0, 0);
    run_job(32'd2, 0, 0);
    run_job(32'd3, 0, 0);
    run_job(32'd958003200, 0, 0);
    run_job(32'hFFFF_FFFF, 0, 0);

    // second start pulse during a busy job must be dropped
    @(negedge clk);
    start    = 1'b1;
    value_in = 32'd240;
    @(posedge clk);
    #1;
    start    = 1'b0;
    value_in = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    value_in = 32'd48;
    @(negedge clk);
    start    = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    check("ignored start n_out", 64'(n_out), 64'd5);
    check("ignored start exact", 64'(exact), 64'd1);
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("ignored start no second done", 64'(dones), 64'd0);
    check("ignored start idle", 64'(busy), 64'd0);

    // start held high: next job accepted after one IDLE cycle
    run_job(32'd240, 1, 32'd48);
    run_job(32'd48, 0, 0);

    // asynchronous reset in the middle of a long job
    @(negedge clk);
    start    = 1'b1;
    value_in = 32'd958003200;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset n_out", 64'(n_out), 64'd0);
    check("async reset exact", 64'(exact), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_job(32'd240, 0, 0);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: v = $urandom;
        1: v = 32'((fact(int'($urandom_range(0, 12))) << 1) + 64'($urandom_range(0, 2)) - 64'd1);
        default: v = $urandom_range(0, 30);
      endcase
      run_job(v, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
